// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus a 32-iteration
// shift-and-add MUL that stalls the pipeline through busy_o.
module alu_multicycle (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [3:0]  ALUCtrl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        zero_o
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SRAI = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        zero_q, zero_d;
    logic        valid_q, valid_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;

    logic [31:0] alu_result;
    logic [31:0] acc_sum;

    always_comb begin
        alu_result = 32'h0;
        case (ALUCtrl_i)
            OP_AND:  alu_result = data1_i & data2_i;
            OP_XOR:  alu_result = data1_i ^ data2_i;
            OP_SLL:  alu_result = data1_i << data2_i[4:0];
            OP_ADD,
            OP_ADDI,
            OP_LW,
            OP_SW:   alu_result = data1_i + data2_i;
            OP_SUB:  alu_result = data1_i - data2_i;
            OP_SRAI: alu_result = $unsigned($signed(data1_i) >>> data2_i[4:0]);
            default: alu_result = 32'h0;
        endcase
    end

    // Partial-product add for the current multiplier bit; also the final result on the last step.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'h0);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (ALUCtrl_i == OP_MUL) begin
                        mcand_d  = data1_i;
                        mplier_d = data2_i;
                        acc_d    = 32'h0;
                        count_d  = 5'd0;
                        state_d  = MUL_BUSY;
                    end else begin
                        data_d  = alu_result;
                        zero_d  = (alu_result == 32'h0);
                        valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    data_d  = acc_sum;
                    zero_d  = (acc_sum == 32'h0);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            data_q   <= 32'h0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
            mcand_q  <= 32'h0;
            mplier_q <= 32'h0;
            acc_q    <= 32'h0;
            count_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == MUL_BUSY);
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: table of single-cycle vectors applied
// back-to-back, plus hand-written MUL, mid-MUL request and reset-abort sequences.
module tb_alu_multicycle;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [3:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        zero_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_zero;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    alu_multicycle dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .zero_o    (zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one request, then let one rising edge pass and settle 1ns after it.
    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        valid_i   = v;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Accept a MUL, scramble operands, optionally fire an ADD mid-flight, and
    // check latency, busy duration, single pulse and the product.
    task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input logic exp_zero,
                          input logic inject);
        int busy_cnt;
        int valid_cnt;
        int valid_at;
        logic [31:0] got_data;
        logic        got_zero;
        busy_cnt  = 0;
        valid_cnt = 0;
        valid_at  = -1;
        got_data  = 32'h0;
        got_zero  = 1'b0;
        applyStimulus(1'b1, 4'b0101, a, b);
        valid_i = 1'b0;
        data1_i = 32'hDEAD_BEEF;
        data2_i = 32'h1234_5677;
        checkOutput({tag, " busy after accept"}, {31'h0, busy_o}, 32'h1);
        checkOutput({tag, " ready after accept"}, {31'h0, ready_o}, 32'h0);
        checkOutput({tag, " valid after accept"}, {31'h0, valid_o}, 32'h0);
        if (busy_o) busy_cnt++;
        for (int k = 1; k <= 40; k++) begin
            if (inject && k == 5) begin
                valid_i   = 1'b1;
                ALUCtrl_i = 4'b0011;
                data1_i   = 32'd1;
                data2_i   = 32'd1;
            end
            if (k == 7) valid_i = 1'b0;
            @(posedge clk_i);
            #1;
            if (busy_o) busy_cnt++;
            if (valid_o) begin
                valid_cnt++;
                if (valid_at < 0) begin
                    valid_at = k;
                    got_data = data_o;
                    got_zero = zero_o;
                end
            end
        end
        valid_i = 1'b0;
        checkOutput({tag, " latency"}, valid_at, 32'd32);
        checkOutput({tag, " busy cycles"}, busy_cnt, 32'd32);
        checkOutput({tag, " valid pulses"}, valid_cnt, 32'd1);
        checkOutput({tag, " data"}, got_data, exp_data);
        checkOutput({tag, " zero"}, {31'h0, got_zero}, {31'h0, exp_zero});
        checkOutput({tag, " data held"}, data_o, exp_data);
    endtask

    initial begin
        int vcnt;

        vecs[0]  = '{4'b0011, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{4'b0100, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
        vecs[2]  = '{4'b0100, 32'd9,          32'd9,          32'h0,          1'b1};
        vecs[3]  = '{4'b0000, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0};
        vecs[4]  = '{4'b0001, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00,  1'b0};
        vecs[5]  = '{4'b0010, 32'd1,          32'd31,         32'h8000_0000,  1'b0};
        vecs[6]  = '{4'b0111, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0};
        vecs[7]  = '{4'b0111, 32'h8000_0000,  32'h0000_0024,  32'hF800_0000,  1'b0};
        vecs[8]  = '{4'b0111, 32'h4000_0000,  32'd2,          32'h1000_0000,  1'b0};
        vecs[9]  = '{4'b0010, 32'd3,          32'h0000_0021,  32'd6,          1'b0};
        vecs[10] = '{4'b0110, 32'hFFFF_FFFF,  32'd1,          32'h0,          1'b1};
        vecs[11] = '{4'b1000, 32'h0000_1000,  32'h0000_0020,  32'h0000_1020,  1'b0};
        vecs[12] = '{4'b1010, 32'd5,          32'd5,          32'h0,          1'b1};
        vecs[13] = '{4'b1111, 32'hFFFF_FFFF,  32'h1,          32'h0,          1'b1};
        vecs[14] = '{4'b1001, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0};

        rst_i     = 1'b1;
        valid_i   = 1'b0;
        ALUCtrl_i = 4'h0;
        data1_i   = 32'h0;
        data2_i   = 32'h0;
        #1;
        checkOutput("reset data",  data_o, 32'h0);
        checkOutput("reset zero",  {31'h0, zero_o}, 32'h0);
        checkOutput("reset valid", {31'h0, valid_o}, 32'h0);
        checkOutput("reset busy",  {31'h0, busy_o}, 32'h0);
        checkOutput("reset ready", {31'h0, ready_o}, 32'h1);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Back-to-back single-cycle requests: one valid pulse per cycle.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d valid", i), {31'h0, valid_o}, 32'h1);
            checkOutput($sformatf("vec%0d data", i), data_o, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d zero", i), {31'h0, zero_o}, {31'h0, vecs[i].exp_zero});
            checkOutput($sformatf("vec%0d ready", i), {31'h0, ready_o}, 32'h1);
        end

        applyStimulus(1'b0, 4'b0011, 32'd100, 32'd200);
        checkOutput("idle valid", {31'h0, valid_o}, 32'h0);
        checkOutput("idle hold data", data_o, vecs[NVEC-1].exp_data);
        checkOutput("idle hold zero", {31'h0, zero_o}, {31'h0, vecs[NVEC-1].exp_zero});

        runMul("mul ffffffff*3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 1'b1);
        runMul("mul 10000*10000", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b0);
        runMul("mul 12345*678", 32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b0);
        runMul("mul ffffffff*3 again", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 1'b0);

        // Reset ten cycles into a MUL must abort it silently.
        applyStimulus(1'b1, 4'b0101, 32'd7, 32'd9);
        valid_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_i);
            #1;
        end
        checkOutput("pre-reset busy", {31'h0, busy_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        checkOutput("abort busy",  {31'h0, busy_o}, 32'h0);
        checkOutput("abort ready", {31'h0, ready_o}, 32'h1);
        checkOutput("abort data",  data_o, 32'h0);
        checkOutput("abort valid", {31'h0, valid_o}, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        applyStimulus(1'b1, 4'b0011, 32'd1, 32'd1);
        valid_i = 1'b0;
        checkOutput("post-reset add valid", {31'h0, valid_o}, 32'h1);
        checkOutput("post-reset add data", data_o, 32'd2);
        vcnt = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) vcnt++;
        end
        checkOutput("aborted mul pulses", vcnt, 32'd0);
        checkOutput("aborted mul data held", data_o, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
